debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent debounced channels (1..16).
REQ-002 Parameter DATA_W, default 4: width of the code captured with each press event.
REQ-003 Parameter DEBOUNCE_CYCLES, default 3984000: stable-sample cycles required to confirm a press or a release (>=2).
REQ-004 Parameter REPEAT_CYCLES, default 0: auto-repeat period in HELD; 0 disables auto-repeat.
REQ-005 Parameter CNT_W, default 22: counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_CYCLES).
REQ-006 One clock; reset is synchronous and active-high. Ports are clk and reset.
REQ-007 clk  in  1  system clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 raw_in  in  N_CH  asynchronous bouncy channel inputs, 1 = pressed.
REQ-010 data_in  in  DATA_W  code sampled when a press event is generated.
REQ-011 stable  out  N_CH  debounced level per channel.
REQ-012 press_pulse  out  N_CH  one-cycle pulse per confirmed press or auto-repeat.
REQ-013 release_pulse  out  N_CH  one-cycle pulse per confirmed release.
REQ-014 event_valid  out  1  pending press event is held.
REQ-015 event_ready  in  1  consumer accepts event this cycle.
REQ-016 event_ch  out  $clog2(N_CH) (min 1)  channel index of the pending event.
REQ-017 event_data  out  DATA_W  data_in captured with the pending event.
REQ-018 overflow  out  1  sticky flag: a press event was dropped.

Function
REQ-019 Each raw_in bit SHALL pass through a 2-flop synchronizer; s[i] denotes the synchronized bit.
REQ-020 Each channel SHALL run its own FSM {IDLE, DB_UP, HELD, DB_DOWN} and its own CNT_W counter.
REQ-021 IDLE: s=1 -> DB_UP with count=0; otherwise stay.
REQ-022 DB_UP: s=0 -> IDLE immediately (abort); s=1 and count==DEBOUNCE_CYCLES-1 -> HELD; else count+1.
REQ-023 HELD: s=0 -> DB_DOWN with count=0; otherwise stay.
REQ-024 DB_DOWN: s=1 -> HELD immediately (no release); s=0 and count==DEBOUNCE_CYCLES-1 -> IDLE; else count+1.
REQ-025 stable[i] SHALL be 1 exactly when channel i is in HELD or DB_DOWN.
REQ-026 press_pulse[i] SHALL be high for exactly the first cycle channel i is in HELD after DB_UP; release_pulse[i] for exactly the first cycle in IDLE after DB_DOWN.
REQ-027 Latency: raw_in held high from edge k enters HELD at edge k+DEBOUNCE_CYCLES+3; press_pulse is high in the following cycle. Release is symmetric.
REQ-028 If REPEAT_CYCLES>0, a repeat counter SHALL run in HELD, cleared on entry; at REPEAT_CYCLES-1 it SHALL pulse press_pulse[i] for one cycle and wrap to 0. It is frozen in DB_DOWN and cleared on return to HELD.
REQ-029 Event capture: in a cycle with any press_pulse bit set, the lowest set index SHALL be the winner.
REQ-030 The winner SHALL load event_ch/event_data(=data_in that cycle) and set event_valid at the next edge if event_valid==0 or event_ready==1.
REQ-031 If event_valid==1 and event_ready==0 when a winner exists, the event SHALL be dropped, the held event SHALL be unchanged, and overflow SHALL set.
REQ-032 Non-winning simultaneous press_pulse bits SHALL set overflow.
REQ-033 event_valid&event_ready with no new winner SHALL clear event_valid next edge; event_ch/event_data hold their values.
REQ-034 overflow SHALL clear only on reset.

Reset
REQ-035 reset=1 at an edge SHALL force all FSMs to IDLE and zero all counters and synchronizers.
REQ-036 Reset SHALL zero stable, press_pulse, release_pulse, event_valid, event_ch, event_data and overflow, including mid-debounce or mid-event.
REQ-037 A key held through reset deassertion SHALL be re-debounced from IDLE and produce a fresh press_pulse.

Verification (DEBOUNCE_CYCLES=8, REPEAT_CYCLES=0 unless noted, N_CH=4)
REQ-038 raw_in[0] high from edge 10, data_in=4'hA -> press_pulse[0] during cycle 21 only; event_valid=1, event_ch=0, event_data=4'hA.
REQ-039 raw_in[1] toggles every 3 cycles for 40 cycles -> no pulses, stable[1]=0 throughout; then held high -> exactly one press_pulse[1].
REQ-040 raw_in[2] and raw_in[3] rise on the same edge, event_ready=1 -> event_ch=2, overflow=1.
REQ-041 Event pending with event_ready=0, second press on ch1 -> event unchanged, overflow=1; assert event_ready -> event_valid=0 next cycle.
REQ-042 REPEAT_CYCLES=20, ch0 held 70 cycles past confirmation -> press_pulses at confirmation +20, +40, +60; then release -> one release_pulse[0].
REQ-043 reset pulsed while ch0 in DB_UP with count=5 and event pending -> all outputs 0 next cycle; ch0 held -> press_pulse 11 cycles after reset drops.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: a bank of independent key/switch debouncers.
// Each channel has a 2-flop synchronizer, a four-state debounce FSM with its
// own stability counter, an optional auto-repeat counter, and registered
// level/press/release outputs. Press events from all channels funnel into a
// single-entry event holding register with a sticky overflow flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | debounced level 0, synchronized input also 0
//   DB_UP   | input went high, counting stable-high samples
//   HELD    | debounced level 1, auto-repeat counter running if enabled
//   DB_DOWN | input went low while held, counting stable-low samples

module debounce_bank #(
  parameter int N_CH            = 4,
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 3984000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 22,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   raw_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [N_CH-1:0]   stable,
  output logic [N_CH-1:0]   press_pulse,
  output logic [N_CH-1:0]   release_pulse,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [CH_W-1:0]   event_ch,
  output logic [DATA_W-1:0] event_data,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DB_UP   = 2'd1,
    HELD    = 2'd2,
    DB_DOWN = 2'd3
  } state_t;

  // Terminal-count values for the stability and repeat counters.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               RPT_EN   = (REPEAT_CYCLES > 0);

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  // Two-flop synchronizer for every raw input bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] rpt_q;
    logic             stable_q;
    logic             press_q;
    logic             release_q;
    logic             s;

    assign s = sync2_q[gi];

    // Per-channel debounce FSM; pulses are registered alongside the state so
    // they line up with the first cycle spent in the new state.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        rpt_q     <= '0;
        stable_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (s) begin
              state_q <= DB_UP;
              cnt_q   <= '0;
            end
          end
          DB_UP: begin
            if (!s) begin
              state_q <= IDLE;
            end else if (cnt_q == DB_LAST) begin
              state_q  <= HELD;
              stable_q <= 1'b1;
              press_q  <= 1'b1;
              rpt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          HELD: begin
            if (!s) begin
              // Repeat counter is left untouched while debouncing the release.
              state_q <= DB_DOWN;
              cnt_q   <= '0;
            end else if (RPT_EN) begin
              if (rpt_q == RPT_LAST) begin
                rpt_q   <= '0;
                press_q <= 1'b1;
              end else begin
                rpt_q <= rpt_q + CNT_ONE;
              end
            end
          end
          DB_DOWN: begin
            if (s) begin
              // A bounce back high restarts the repeat period from zero.
              state_q <= HELD;
              rpt_q   <= '0;
            end else if (cnt_q == DB_LAST) begin
              state_q   <= IDLE;
              stable_q  <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q  <= IDLE;
            stable_q <= 1'b0;
          end
        endcase
      end
    end

    assign stable[gi]        = stable_q;
    assign press_pulse[gi]   = press_q;
    assign release_pulse[gi] = release_q;
  end

  logic            win_found;
  logic [CH_W-1:0] win_idx;
  logic            multi_press;

  // Lowest-index press pulse wins; any additional simultaneous pulse is lost.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press_pulse[i]) begin
        win_found = 1'b1;
        win_idx   = CH_W'(i);
      end
    end
  end

  assign multi_press = |(press_pulse & (press_pulse - {{(N_CH-1){1'b0}}, 1'b1}));

  // Single-entry event holding register with sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_valid <= 1'b0;
      event_ch    <= '0;
      event_data  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (win_found) begin
        if (!event_valid || event_ready) begin
          event_valid <= 1'b1;
          event_ch    <= win_idx;
          event_data  <= data_in;
        end else begin
          overflow <= 1'b1;
        end
        if (multi_press) begin
          overflow <= 1'b1;
        end
      end else if (event_valid && event_ready) begin
        event_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: two debounce_bank instances (no repeat / repeat every 20)
// share stimulus; a run-length model of each bank is checked every cycle,
// and directed sequences pin exact latencies and event behaviour.

module tb_debounce_bank;

  localparam int NCH = 4;
  localparam int DW  = 4;
  localparam int DB  = 8;
  localparam int NI  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NCH-1:0] raw_in = '0;
  logic [DW-1:0]  data_in = '0;
  logic           event_ready = 1'b0;

  logic [NCH-1:0] stb [NI];
  logic [NCH-1:0] prs [NI];
  logic [NCH-1:0] rls [NI];
  logic           evv [NI];
  logic [1:0]     evc [NI];
  logic [DW-1:0]  evd [NI];
  logic           ovf [NI];

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  debounce_bank #(.N_CH(NCH), .DATA_W(DW), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(0), .CNT_W(5)) u0 (
    .clk(clk), .reset(reset), .raw_in(raw_in), .data_in(data_in),
    .stable(stb[0]), .press_pulse(prs[0]), .release_pulse(rls[0]),
    .event_valid(evv[0]), .event_ready(event_ready), .event_ch(evc[0]),
    .event_data(evd[0]), .overflow(ovf[0]));

  debounce_bank #(.N_CH(NCH), .DATA_W(DW), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(20), .CNT_W(5)) u1 (
    .clk(clk), .reset(reset), .raw_in(raw_in), .data_in(data_in),
    .stable(stb[1]), .press_pulse(prs[1]), .release_pulse(rls[1]),
    .event_valid(evv[1]), .event_ready(event_ready), .event_ch(evc[1]),
    .event_data(evd[1]), .overflow(ovf[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a level flips once the synchronized input has
  // disagreed with it for DB+1 consecutive samples; repeats count agreeing
  // samples while held.
  int rp [NI] = '{0, 20};
  bit m_s1 [NI][NCH];
  bit m_s2 [NI][NCH];
  bit m_lvl [NI][NCH];
  int m_run [NI][NCH];
  int m_rep [NI][NCH];
  bit m_prs [NI][NCH];
  bit m_rls [NI][NCH];
  bit m_evv [NI];
  int m_evc [NI];
  logic [DW-1:0] m_evd [NI];
  bit m_ovf [NI];

  always @(posedge clk) begin : model
    int win;
    int cnt;
    bit s;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        for (int c = 0; c < NCH; c++) begin
          m_s1[i][c] = 0; m_s2[i][c] = 0; m_lvl[i][c] = 0;
          m_run[i][c] = 0; m_rep[i][c] = 0; m_prs[i][c] = 0; m_rls[i][c] = 0;
        end
        m_evv[i] = 0; m_evc[i] = 0; m_evd[i] = '0; m_ovf[i] = 0;
      end else begin
        win = -1;
        cnt = 0;
        for (int c = 0; c < NCH; c++) begin
          if (m_prs[i][c]) begin
            cnt++;
            if (win < 0) win = c;
          end
        end
        if (win >= 0) begin
          if (!m_evv[i] || event_ready) begin
            m_evv[i] = 1; m_evc[i] = win; m_evd[i] = data_in;
          end else begin
            m_ovf[i] = 1;
          end
          if (cnt > 1) m_ovf[i] = 1;
        end else if (m_evv[i] && event_ready) begin
          m_evv[i] = 0;
        end
        for (int c = 0; c < NCH; c++) begin
          s = m_s2[i][c];
          m_s2[i][c] = m_s1[i][c];
          m_s1[i][c] = raw_in[c];
          m_prs[i][c] = 0;
          m_rls[i][c] = 0;
          if (s != m_lvl[i][c]) begin
            m_run[i][c]++;
            if (m_run[i][c] == DB + 1) begin
              m_lvl[i][c] = s;
              m_run[i][c] = 0;
              m_rep[i][c] = 0;
              if (s) m_prs[i][c] = 1; else m_rls[i][c] = 1;
            end
          end else begin
            if (m_lvl[i][c] && rp[i] > 0) begin
              if (m_run[i][c] > 0) m_rep[i][c] = 0;
              else if (m_rep[i][c] == rp[i] - 1) begin
                m_rep[i][c] = 0;
                m_prs[i][c] = 1;
              end else m_rep[i][c]++;
            end
            m_run[i][c] = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : compare
    logic [NCH-1:0] ms, mp, mr;
    if (cmp_en) begin
      for (int i = 0; i < NI; i++) begin
        for (int c = 0; c < NCH; c++) begin
          ms[c] = m_lvl[i][c]; mp[c] = m_prs[i][c]; mr[c] = m_rls[i][c];
        end
        check($sformatf("u%0d.stable", i), 32'(stb[i]), 32'(ms));
        check($sformatf("u%0d.press_pulse", i), 32'(prs[i]), 32'(mp));
        check($sformatf("u%0d.release_pulse", i), 32'(rls[i]), 32'(mr));
        check($sformatf("u%0d.event_valid", i), 32'(evv[i]), 32'(m_evv[i]));
        check($sformatf("u%0d.event_ch", i), 32'(evc[i]), 32'(m_evc[i]));
        check($sformatf("u%0d.event_data", i), 32'(evd[i]), 32'(m_evd[i]));
        check($sformatf("u%0d.overflow", i), 32'(ovf[i]), 32'(m_ovf[i]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    raw_in = '0;
    event_ready = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] all_out(input int i);
    return {stb[i], prs[i], rls[i], 3'b0, evv[i], 2'b0, evc[i], evd[i], 3'b0, ovf[i]};
  endfunction

  initial begin : stim
    int seg [NCH];
    int hits;
    int found;
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
    cmp_en = 1'b1;
    check("reset_outputs_u0", all_out(0), 32'h0);
    check("reset_outputs_u1", all_out(1), 32'h0);
    reset = 1'b0;

    // Single press on ch0: pulse exactly 11 cycles after the input rises.
    data_in = 4'hA;
    raw_in[0] = 1'b1;
    cyc(10);
    check("p38_press_early", 32'(prs[0][0]), 32'd0);
    cyc(1);
    check("p38_press", 32'(prs[0][0]), 32'd1);
    check("p38_stable", 32'(stb[0][0]), 32'd1);
    cyc(1);
    check("p38_press_once", 32'(prs[0][0]), 32'd0);
    check("p38_ev_valid", 32'(evv[0]), 32'd1);
    check("p38_ev_ch", 32'(evc[0]), 32'd0);
    check("p38_ev_data", 32'(evd[0]), 32'hA);

    // Bouncy ch1 never confirms; then a steady hold gives one press.
    do_reset();
    event_ready = 1'b1;
    hits = 0;
    for (int t = 0; t < 42; t++) begin
      if (t % 3 == 0) raw_in[1] = ~raw_in[1];
      cyc(1);
      if (stb[0][1] || prs[0][1]) hits++;
    end
    check("p39_bounce_quiet", 32'(hits), 32'd0);
    raw_in[1] = 1'b1;
    hits = 0;
    for (int t = 0; t < 25; t++) begin
      cyc(1);
      if (prs[0][1]) hits++;
    end
    check("p39_single_press", 32'(hits), 32'd1);

    // Simultaneous ch2/ch3: lowest wins, other sets overflow.
    do_reset();
    event_ready = 1'b1;
    data_in = 4'h6;
    raw_in[3:2] = 2'b11;
    cyc(11);
    check("p40_ovf_before", 32'(ovf[0]), 32'd0);
    cyc(1);
    check("p40_ev_ch", 32'(evc[0]), 32'd2);
    check("p40_ovf", 32'(ovf[0]), 32'd1);

    // Pending event blocks a second press, which is dropped.
    do_reset();
    data_in = 4'h3;
    raw_in[0] = 1'b1;
    cyc(12);
    check("p41_first_valid", 32'(evv[0]), 32'd1);
    data_in = 4'h5;
    raw_in[1] = 1'b1;
    cyc(12);
    check("p41_ev_ch_kept", 32'(evc[0]), 32'd0);
    check("p41_ev_data_kept", 32'(evd[0]), 32'h3);
    check("p41_ovf", 32'(ovf[0]), 32'd1);
    event_ready = 1'b1;
    cyc(1);
    event_ready = 1'b0;
    check("p41_drained", 32'(evv[0]), 32'd0);
    check("p41_ch_hold", 32'(evc[0]), 32'd0);

    // Auto-repeat on u1 at +20/+40/+60 after confirmation, then one release.
    do_reset();
    event_ready = 1'b1;
    raw_in[0] = 1'b1;
    found = 0;
    for (int t = 0; t < 30 && found == 0; t++) begin
      cyc(1);
      if (prs[1][0]) found = 1;
    end
    check("p42_confirm_seen", 32'(found), 32'd1);
    for (int j = 1; j <= 70; j++) begin
      cyc(1);
      check($sformatf("p42_repeat_%0d", j), 32'(prs[1][0]), 32'((j % 20) == 0));
    end
    raw_in[0] = 1'b0;
    hits = 0;
    for (int t = 0; t < 20; t++) begin
      cyc(1);
      if (rls[1][0]) hits++;
    end
    check("p42_one_release", 32'(hits), 32'd1);

    // Reset mid-debounce with an event pending, then fresh press after reset.
    do_reset();
    raw_in[1] = 1'b1;
    cyc(12);
    check("p43_pending", 32'(evv[0]), 32'd1);
    raw_in[0] = 1'b1;
    cyc(8);
    reset = 1'b1;
    cyc(1);
    check("p43_cleared_u0", all_out(0), 32'h0);
    check("p43_cleared_u1", all_out(1), 32'h0);
    reset = 1'b0;
    cyc(10);
    check("p43_press_early", 32'(prs[0][0]), 32'd0);
    cyc(1);
    check("p43_press", 32'(prs[0][0]), 32'd1);

    // Random phase: mixed bounces and long holds, random handshake and resets.
    do_reset();
    for (int c = 0; c < NCH; c++) seg[c] = $urandom_range(1, 10);
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (seg[c] == 0) begin
          raw_in[c] = ~raw_in[c];
          seg[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 45);
        end else begin
          seg[c]--;
        end
      end
      data_in = 4'($urandom_range(0, 15));
      event_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 699) == 0);
    end
    reset = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
